// File: rtl/cfg_pkg.sv
// Build-wide configuration for the stack subsystem: engine count and the
// default response watchdog limit.
package cfg_pkg;
  localparam int unsigned ENGS_N            = 4;
  localparam int unsigned STK_RSP_TIMEOUT_N = 255;
endpackage

// File: rtl/stk_pkg.sv
// Shared stack types: pipe opcodes, engine identifiers and the request FSM states.
package stk_pkg;
  localparam int unsigned ENGID_W = (cfg_pkg::ENGS_N > 1) ? $clog2(cfg_pkg::ENGS_N) : 1;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } opcode_t;

  typedef logic [ENGID_W-1:0] engid_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RSP      = 2'd3
  } state_t;
endpackage

// File: rtl/stk_eng_req.sv
// Per-engine request front end: captures one request, issues it to the shared
// stack pipe, waits for the tagged response (or watchdog expiry) and returns it.
module stk_eng_req
  import stk_pkg::*;
#(
  parameter int unsigned ENG_ID    = 0,
  parameter int unsigned TIMEOUT_N = cfg_pkg::STK_RSP_TIMEOUT_N
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_req_vld,
  input  opcode_t       i_req_opcode,
  input  logic [127:0]  i_req_dat,
  output logic          o_req_rdy,
  output opcode_t       o_cmd_opcode,
  output logic [127:0]  o_cmd_dat,
  input  logic          i_cmd_ack,
  input  engid_t        i_cmd_ack_engid,
  input  logic          i_rsp_vld,
  input  engid_t        i_rsp_engid,
  input  logic [127:0]  i_rsp_dat,
  input  logic          i_rsp_err,
  output logic          o_rsp_vld,
  output logic [127:0]  o_rsp_dat,
  output logic          o_rsp_err,
  output logic          o_rsp_timeout
);

  localparam engid_t     MY_ID   = engid_t'(ENG_ID);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_N - 1);

  state_t        state_q, state_d;
  opcode_t       op_q, op_d;
  logic [127:0]  dat_q, dat_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [127:0]  rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_to_q, rsp_to_d;

  logic ack_hit;
  logic rsp_hit;

  assign ack_hit = i_cmd_ack && (i_cmd_ack_engid == MY_ID);
  assign rsp_hit = i_rsp_vld && (i_rsp_engid == MY_ID);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rsp_to_d  = rsp_to_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_vld && (i_req_opcode != NOP)) begin
          op_d    = i_req_opcode;
          dat_d   = i_req_dat;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_hit) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        cnt_d = cnt_q + 8'd1;
        // A real response on the expiry cycle takes priority over the watchdog.
        if (rsp_hit) begin
          rsp_dat_d = i_rsp_dat;
          rsp_err_d = i_rsp_err;
          rsp_to_d  = 1'b0;
          state_d   = ST_RSP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b1;
          state_d   = ST_RSP;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= NOP;
      dat_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rsp_to_q  <= rsp_to_d;
    end
  end

  assign o_req_rdy     = (state_q == ST_IDLE);
  assign o_cmd_opcode  = (state_q == ST_ISSUE) ? op_q : NOP;
  assign o_cmd_dat     = (state_q == ST_ISSUE) ? dat_q : '0;
  assign o_rsp_vld     = (state_q == ST_RSP);
  assign o_rsp_dat     = rsp_dat_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_stk_eng_req.sv
// Directed bench for stk_eng_req (ENG_ID=1, TIMEOUT_N=4): a transaction table
// plus hand sequences for NOP drop, idle responses and reset mid-operation.
module tb_stk_eng_req;
  import stk_pkg::*;

  localparam int unsigned ENG_ID    = 1;
  localparam int unsigned TIMEOUT_N = 4;
  localparam engid_t      MY_ID     = engid_t'(ENG_ID);
  localparam engid_t      OTHER_ID  = engid_t'(ENG_ID + 1);

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_req_vld;
  opcode_t       i_req_opcode;
  logic [127:0]  i_req_dat;
  logic          o_req_rdy;
  opcode_t       o_cmd_opcode;
  logic [127:0]  o_cmd_dat;
  logic          i_cmd_ack;
  engid_t        i_cmd_ack_engid;
  logic          i_rsp_vld;
  engid_t        i_rsp_engid;
  logic [127:0]  i_rsp_dat;
  logic          i_rsp_err;
  logic          o_rsp_vld;
  logic [127:0]  o_rsp_dat;
  logic          o_rsp_err;
  logic          o_rsp_timeout;

  always #5 clk = ~clk;

  stk_eng_req #(.ENG_ID(ENG_ID), .TIMEOUT_N(TIMEOUT_N)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .i_req_vld       (i_req_vld),
    .i_req_opcode    (i_req_opcode),
    .i_req_dat       (i_req_dat),
    .o_req_rdy       (o_req_rdy),
    .o_cmd_opcode    (o_cmd_opcode),
    .o_cmd_dat       (o_cmd_dat),
    .i_cmd_ack       (i_cmd_ack),
    .i_cmd_ack_engid (i_cmd_ack_engid),
    .i_rsp_vld       (i_rsp_vld),
    .i_rsp_engid     (i_rsp_engid),
    .i_rsp_dat       (i_rsp_dat),
    .i_rsp_err       (i_rsp_err),
    .o_rsp_vld       (o_rsp_vld),
    .o_rsp_dat       (o_rsp_dat),
    .o_rsp_err       (o_rsp_err),
    .o_rsp_timeout   (o_rsp_timeout)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    opcode_t      op;
    logic [127:0] req_dat;
    int           ack_delay;   // ISSUE cycles before the matching ack
    bit           foreign;     // inject other-engine ack/rsp while waiting
    int           rsp_delay;   // WAIT_RSP cycle index of matching rsp, -1 = none
    logic [127:0] rsp_dat;
    logic         rsp_err;
    logic [127:0] exp_dat;
    logic         exp_err;
    logic         exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req_vld       = 1'b0;
    i_req_opcode    = NOP;
    i_req_dat       = '0;
    i_cmd_ack       = 1'b0;
    i_cmd_ack_engid = '0;
    i_rsp_vld       = 1'b0;
    i_rsp_engid     = '0;
    i_rsp_dat       = '0;
    i_rsp_err       = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int exp_n;
    bit seen;
    @(negedge clk);
    chk("idle_rdy", 128'(o_req_rdy), 128'(1'b1));
    i_req_vld    = 1'b1;
    i_req_opcode = v.op;
    i_req_dat    = v.req_dat;
    @(negedge clk);
    idle_inputs();
    chk("issue_op", 128'(o_cmd_opcode), 128'(v.op));
    chk("issue_dat", o_cmd_dat, v.req_dat);
    chk("issue_rdy", 128'(o_req_rdy), 128'(1'b0));
    for (int i = 0; i < v.ack_delay; i++) begin
      if (v.foreign) begin
        // Other engine's ack, and a matching rsp arriving too early: both ignored.
        i_cmd_ack       = 1'b1;
        i_cmd_ack_engid = OTHER_ID;
        i_rsp_vld       = 1'b1;
        i_rsp_engid     = MY_ID;
        i_rsp_dat       = 128'hDEAD;
        i_rsp_err       = 1'b1;
      end
      @(negedge clk);
      idle_inputs();
      chk("hold_op", 128'(o_cmd_opcode), 128'(v.op));
      chk("hold_dat", o_cmd_dat, v.req_dat);
      chk("hold_novld", 128'(o_rsp_vld), 128'(1'b0));
    end
    i_cmd_ack       = 1'b1;
    i_cmd_ack_engid = MY_ID;
    @(negedge clk);
    idle_inputs();
    chk("wait_nop", 128'(o_cmd_opcode), 128'(NOP));
    n     = 0;
    seen  = 1'b0;
    exp_n = (v.rsp_delay >= 0) ? v.rsp_delay + 1 : int'(TIMEOUT_N);
    while (!seen && n < 20) begin
      if (n == v.rsp_delay) begin
        i_rsp_vld   = 1'b1;
        i_rsp_engid = MY_ID;
        i_rsp_dat   = v.rsp_dat;
        i_rsp_err   = v.rsp_err;
      end else if (v.foreign) begin
        i_rsp_vld   = 1'b1;
        i_rsp_engid = OTHER_ID;
        i_rsp_dat   = 128'hF0F0;
        i_rsp_err   = 1'b1;
      end
      @(negedge clk);
      idle_inputs();
      n++;
      if (o_rsp_vld) seen = 1'b1;
    end
    chk("rsp_seen", 128'(seen), 128'(1'b1));
    chk("rsp_latency", 128'(n), 128'(exp_n));
    chk("rsp_dat", o_rsp_dat, v.exp_dat);
    chk("rsp_err", 128'(o_rsp_err), 128'(v.exp_err));
    chk("rsp_timeout", 128'(o_rsp_timeout), 128'(v.exp_to));
    @(negedge clk);
    chk("post_novld", 128'(o_rsp_vld), 128'(1'b0));
    chk("post_hold_dat", o_rsp_dat, v.exp_dat);
    chk("post_rdy", 128'(o_req_rdy), 128'(1'b1));
    $display("txn %0d op=%s ack_dly=%0d rsp_dly=%0d -> rsp_dat=%h err=%0b to=%0b cycles=%0d",
             idx, v.op.name(), v.ack_delay, v.rsp_delay, o_rsp_dat, o_rsp_err, o_rsp_timeout, n);
  endtask

  initial begin
    logic [127:0] wide;
    bit           any_vld;
    wide = {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
    //            op    req_dat       ack f  rsp  rsp_dat        err  exp_dat        err  to
    vecs[0] = '{PUSH, 128'h1234,       0, 0,  0, 128'h0,         0, 128'h0,         0, 0};
    vecs[1] = '{POP,  128'h0,          5, 0,  1, 128'hCAFE,      0, 128'hCAFE,      0, 0};
    vecs[2] = '{PUSH, 128'hAAAA,       2, 1,  2, 128'h55,        1, 128'h55,        1, 0};
    vecs[3] = '{POP,  128'h0,          1, 1, -1, 128'h0,         0, 128'h0,         1, 1};
    vecs[4] = '{PUSH, 128'h77,         0, 0,  3, 128'h77,        1, 128'h77,        1, 0};
    vecs[5] = '{POP,  wide,            0, 0, -1, 128'h0,         0, 128'h0,         1, 1};
    vecs[6] = '{POP,  128'h0,          0, 0,  3, wide,           0, wide,           0, 0};

    idle_inputs();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 128'(o_req_rdy), 128'(1'b1));
    chk("rst_cmd_op", 128'(o_cmd_opcode), 128'(NOP));
    chk("rst_cmd_dat", o_cmd_dat, 128'h0);
    chk("rst_rsp_vld", 128'(o_rsp_vld), 128'(1'b0));
    chk("rst_rsp_flags", 128'({o_rsp_err, o_rsp_timeout}), 128'(2'b00));
    arst_n = 1'b1;

    // NOP request is dropped.
    @(negedge clk);
    i_req_vld    = 1'b1;
    i_req_opcode = NOP;
    i_req_dat    = 128'h99;
    @(negedge clk);
    idle_inputs();
    chk("nop_rdy", 128'(o_req_rdy), 128'(1'b1));
    chk("nop_cmd", 128'(o_cmd_opcode), 128'(NOP));
    $display("txn nop: rdy=%0b cmd=%s", o_req_rdy, o_cmd_opcode.name());

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Matching response while IDLE is ignored; outputs keep the last response.
    i_rsp_vld   = 1'b1;
    i_rsp_engid = MY_ID;
    i_rsp_dat   = 128'hBAD;
    i_rsp_err   = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("idle_rsp_novld", 128'(o_rsp_vld), 128'(1'b0));
    chk("idle_rsp_hold", o_rsp_dat, wide);
    chk("idle_rsp_rdy", 128'(o_req_rdy), 128'(1'b1));
    $display("txn idle_rsp: vld=%0b dat=%h", o_rsp_vld, o_rsp_dat);

    // Reset in WAIT_RSP, then a late response after release.
    i_req_vld    = 1'b1;
    i_req_opcode = PUSH;
    i_req_dat    = 128'h9;
    @(negedge clk);
    idle_inputs();
    i_cmd_ack       = 1'b1;
    i_cmd_ack_engid = MY_ID;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 128'(o_req_rdy), 128'(1'b1));
    chk("mid_rst_cmd", 128'(o_cmd_opcode), 128'(NOP));
    chk("mid_rst_rsp_vld", 128'(o_rsp_vld), 128'(1'b0));
    chk("mid_rst_rsp_dat", o_rsp_dat, 128'h0);
    @(negedge clk);
    arst_n      = 1'b1;
    i_rsp_vld   = 1'b1;
    i_rsp_engid = MY_ID;
    i_rsp_dat   = 128'h1A7E;
    i_rsp_err   = 1'b0;
    any_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      if (o_rsp_vld) any_vld = 1'b1;
    end
    chk("late_rsp_ignored", 128'(any_vld), 128'(1'b0));
    chk("late_rsp_dat", o_rsp_dat, 128'h0);
    chk("late_rsp_rdy", 128'(o_req_rdy), 128'(1'b1));
    $display("txn reset_mid_wait: rsp_vld_seen=%0b rdy=%0b", any_vld, o_req_rdy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stk_eng_req.md
STK_ENG_REQ -- requirements
Module: stk_eng_req

Interface
REQ-001 Parameter ENG_ID, default 0, engine index this instance serves (0 .. cfg_pkg::ENGS_N-1).
REQ-002 Parameter TIMEOUT_N, default 255, response watchdog limit in cycles (1..255).
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req_vld  input  1  engine request valid.
REQ-006 i_req_opcode  input  stk_pkg::opcode_t  requested operation (PUSH/POP).
REQ-007 i_req_dat  input  128  push payload.
REQ-008 o_req_rdy  output  1  block accepts request this cycle.
REQ-009 o_cmd_opcode  output  stk_pkg::opcode_t  command to stk_pipe slot ENG_ID; NOP when idle.
REQ-010 o_cmd_dat  output  128  command payload.
REQ-011 i_cmd_ack  input  1  stk_pipe command accept strobe.
REQ-012 i_cmd_ack_engid  input  stk_pkg::engid_t  engine whose command was accepted.
REQ-013 i_rsp_vld  input  1  stk_pipe response valid.
REQ-014 i_rsp_engid  input  stk_pkg::engid_t  response destination engine.
REQ-015 i_rsp_dat  input  128  pop data.
REQ-016 i_rsp_err  input  1  stack empty/full error.
REQ-017 o_rsp_vld  output  1  one-cycle response strobe to engine.
REQ-018 o_rsp_dat  output  128  response data.
REQ-019 o_rsp_err  output  1  error (pipe error or timeout).
REQ-020 o_rsp_timeout  output  1  response was generated by watchdog.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT_RSP, RSP; one-hot or encoded, implementer's choice.
REQ-022 IDLE: o_req_rdy=1; i_req_vld with opcode != NOP captures opcode/dat into registers, next state ISSUE; NOP request is dropped, stays IDLE.
REQ-023 ISSUE: o_cmd_opcode/o_cmd_dat driven from capture registers, held stable until ack; o_req_rdy=0.
REQ-024 ISSUE exit: i_cmd_ack & i_cmd_ack_engid==ENG_ID -> WAIT_RSP next cycle, o_cmd_opcode=NOP from that cycle; ack for other engid ignored.
REQ-025 WAIT_RSP: 8-bit counter cleared on entry, increments each cycle; i_rsp_vld & i_rsp_engid==ENG_ID registers dat/err -> RSP.
REQ-026 WAIT_RSP watchdog: counter == TIMEOUT_N-1 with no matching response -> RSP with o_rsp_err=1, o_rsp_timeout=1, o_rsp_dat=0.
REQ-027 Matching response and watchdog expiry in same cycle: response wins, o_rsp_timeout=0.
REQ-028 RSP: o_rsp_vld=1 exactly one cycle, data/err/timeout valid that cycle; next state IDLE.
REQ-029 Responses with matching engid in IDLE, ISSUE or RSP are ignored (no output, no state change).
REQ-030 Latency: request accept to command visible = 1 cycle; matching response to o_rsp_vld = 1 cycle.
REQ-031 Max one outstanding command; minimum request-to-request interval 4 cycles.
REQ-032 o_rsp_dat, o_rsp_err, o_rsp_timeout hold last value outside RSP; o_rsp_vld=0 outside RSP.

Reset
REQ-033 arst_n low: state IDLE, o_req_rdy=1, o_cmd_opcode=NOP, o_cmd_dat=0, o_rsp_vld=0, o_rsp_dat=0, o_rsp_err=0, o_rsp_timeout=0, counter=0.
REQ-034 Reset mid-operation discards the outstanding command; no response generated after deassert.

Structure
REQ-035 opcode_t (NOP/PUSH/POP) and engid_t stay in stk_pkg; add state_t for this FSM to stk_pkg.
REQ-036 TIMEOUT_N default constant STK_RSP_TIMEOUT_N defined in cfg_pkg.
REQ-037 No sub-module; stk_pipe's parent instantiates ENGS_N copies, one per engine, ENG_ID=index.

Verification
REQ-038 Push: req PUSH dat=0x1234 -> next cycle o_cmd_opcode=PUSH, dat=0x1234; ack engid=ENG_ID -> NOP; rsp err=0 -> o_rsp_vld 1 cycle, err=0.
REQ-039 Pop: req POP, ack delayed 5 cycles -> command held stable 5 cycles; rsp dat=0xCAFE -> o_rsp_dat=0xCAFE one cycle later.
REQ-040 Foreign traffic: ack and rsp with engid=ENG_ID+1 in ISSUE/WAIT_RSP -> no state change, no o_rsp_vld.
REQ-041 Timeout TIMEOUT_N=4: ack, no rsp -> o_rsp_vld after 4 cycles in WAIT_RSP, err=1, timeout=1, dat=0.
REQ-042 Race: matching rsp on expiry cycle -> o_rsp_vld with err=i_rsp_err, timeout=0.
REQ-043 Reset asserted in WAIT_RSP -> all outputs at reset values; late rsp after deassert ignored.
